// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts an opcode and operands, drives the registered
// control/operand inputs of a 16-bit combinational ALU, captures its result
// and flags one cycle later, and returns them over a valid/ready handshake.
// A result accumulator can stand in for operand B to chain operations.
module alu_op_sequencer #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_use_acc,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_zx,
   output logic             alu_nx,
   output logic             alu_zy,
   output logic             alu_ny,
   output logic [1:0]       alu_f,
   output logic             alu_no,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zr,
   input  logic             alu_ng,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_zr,
   output logic             res_ng,
   output logic             res_err,
   output logic [WIDTH-1:0] acc
);

   localparam int unsigned ST_W   = 2;
   localparam int unsigned CTRL_W = 7;

   localparam logic [ST_W-1:0] S_IDLE = 2'd0;
   localparam logic [ST_W-1:0] S_EXEC = 2'd1;
   localparam logic [ST_W-1:0] S_RESP = 2'd2;

   logic [ST_W-1:0]   state;
   logic [ST_W-1:0]   state_next;
   logic              in_ready_next;
   logic              res_valid_next;
   logic              accept;
   logic              legal;
   logic [CTRL_W-1:0] ctrl;   // {zx, nx, zy, ny, f[1:0], no}

   // in_ready is a flop that mirrors IDLE, so the handshake is just valid&ready
   assign accept = in_valid & in_ready;

   // Opcode to ALU control-field decode; ops above 12 are illegal
   always_comb begin
      ctrl  = '0;
      legal = 1'b1;
      case (in_op)
         4'd0:    ctrl = 7'b1010_01_0;   // ZERO
         4'd1:    ctrl = 7'b1111_01_1;   // ONE
         4'd2:    ctrl = 7'b1110_01_0;   // NEG1
         4'd3:    ctrl = 7'b0011_00_0;   // PASSA
         4'd4:    ctrl = 7'b1100_00_0;   // PASSB
         4'd5:    ctrl = 7'b0011_00_1;   // NOTA
         4'd6:    ctrl = 7'b0011_01_1;   // NEGA
         4'd7:    ctrl = 7'b0111_01_1;   // INCA
         4'd8:    ctrl = 7'b0011_01_0;   // DECA
         4'd9:    ctrl = 7'b0000_01_0;   // ADD
         4'd10:   ctrl = 7'b0100_01_1;   // SUB (A-B)
         4'd11:   ctrl = 7'b0000_00_0;   // AND
         4'd12:   ctrl = 7'b0101_00_1;   // OR
         default: legal = 1'b0;
      endcase
   end

   // Next-state logic and the registered handshake outputs derived from it
   always_comb begin
      state_next     = state;
      in_ready_next  = 1'b0;
      res_valid_next = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_next = legal ? S_EXEC : S_RESP;
            end
         end
         S_EXEC: begin
            state_next = S_RESP;
         end
         S_RESP: begin
            if (res_valid && res_ready) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
      in_ready_next  = (state_next == S_IDLE);
      res_valid_next = (state_next == S_RESP);
   end

   // State register with handshake output flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         res_valid <= 1'b0;
      end else begin
         state     <= state_next;
         in_ready  <= in_ready_next;
         res_valid <= res_valid_next;
      end
   end

   // ALU input registers: loaded only when a legal op is accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_a  <= '0;
         alu_b  <= '0;
         alu_zx <= 1'b0;
         alu_nx <= 1'b0;
         alu_zy <= 1'b0;
         alu_ny <= 1'b0;
         alu_f  <= 2'b00;
         alu_no <= 1'b0;
      end else if (accept && legal) begin
         alu_a  <= in_a;
         alu_b  <= in_use_acc ? acc : in_b;
         alu_zx <= ctrl[6];
         alu_nx <= ctrl[5];
         alu_zy <= ctrl[4];
         alu_ny <= ctrl[3];
         alu_f  <= ctrl[2:1];
         alu_no <= ctrl[0];
      end
   end

   // Result capture: ALU result after EXEC, or an error response for illegal ops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_data <= '0;
         res_zr   <= 1'b0;
         res_ng   <= 1'b0;
         res_err  <= 1'b0;
         acc      <= '0;
      end else if (state == S_EXEC) begin
         res_data <= alu_out;
         res_zr   <= alu_zr;
         res_ng   <= alu_ng;
         res_err  <= 1'b0;
         acc      <= alu_out;
      end else if (accept && !legal) begin
         res_data <= '0;
         res_zr   <= 1'b0;
         res_ng   <= 1'b0;
         res_err  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a combinational ALU model closes the loop,
// a transaction-level model predicts every output each cycle, and directed
// operations carry hand-computed literal results.
module tb_alu_op_sequencer;

   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   in_op;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_use_acc;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic         alu_zx, alu_nx, alu_zy, alu_ny, alu_no;
   logic [1:0]   alu_f;
   logic [W-1:0] alu_out;
   logic         alu_zr, alu_ng;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] res_data;
   logic         res_zr, res_ng, res_err;
   logic [W-1:0] acc;

   int n_cmp = 0;
   int n_bad = 0;

   alu_op_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_use_acc(in_use_acc),
      .alu_a(alu_a), .alu_b(alu_b),
      .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
      .alu_f(alu_f), .alu_no(alu_no),
      .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_zr(res_zr), .res_ng(res_ng), .res_err(res_err),
      .acc(acc)
   );

   always #5 clk = ~clk;

   // Combinational ALU attached to the sequencer
   always_comb begin
      logic [W-1:0] x, y, o;
      x = alu_zx ? '0 : alu_a;
      x = alu_nx ? ~x : x;
      y = alu_zy ? '0 : alu_b;
      y = alu_ny ? ~y : y;
      o = alu_f[0] ? W'(x + y) : (x & y);
      o = alu_no ? ~o : o;
      alu_out = o;
      alu_zr  = (o == '0);
      alu_ng  = o[W-1];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Arithmetic meaning of each opcode
   function automatic logic [W-1:0] op_result(input logic [3:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      case (op)
         4'd0:    return '0;
         4'd1:    return W'(1);
         4'd2:    return '1;
         4'd3:    return a;
         4'd4:    return b;
         4'd5:    return ~a;
         4'd6:    return W'(0 - a);
         4'd7:    return W'(a + 1);
         4'd8:    return W'(a - 1);
         4'd9:    return W'(a + b);
         4'd10:   return W'(a - b);
         4'd11:   return a & b;
         4'd12:   return a | b;
         default: return '0;
      endcase
   endfunction

   // Transaction model: 0 waiting for a request, 1 result pending, 2 result offered
   int           m_phase;
   logic [W-1:0] m_pend, m_data, m_acc, m_alu_a, m_alu_b;
   logic         m_zr, m_ng, m_err, m_rv, m_rdy;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0; m_pend = '0; m_data = '0; m_acc = '0;
         m_alu_a = '0; m_alu_b = '0;
         m_zr = 1'b0; m_ng = 1'b0; m_err = 1'b0; m_rv = 1'b0; m_rdy = 1'b1;
      end else begin
         case (m_phase)
            0: if (in_valid) begin
               if (in_op <= 4'd12) begin
                  m_alu_a = in_a;
                  m_alu_b = in_use_acc ? m_acc : in_b;
                  m_pend  = op_result(in_op, m_alu_a, m_alu_b);
                  m_phase = 1;
                  m_rdy   = 1'b0;
               end else begin
                  m_data = '0; m_zr = 1'b0; m_ng = 1'b0; m_err = 1'b1;
                  m_rv = 1'b1; m_rdy = 1'b0; m_phase = 2;
               end
            end
            1: begin
               m_data = m_pend; m_zr = (m_pend == '0); m_ng = m_pend[W-1];
               m_err = 1'b0; m_acc = m_pend; m_rv = 1'b1; m_phase = 2;
            end
            default: if (res_ready) begin
               m_rv = 1'b0; m_rdy = 1'b1; m_phase = 0;
            end
         endcase
      end
   end

   // Per-cycle comparison against the model, sampled mid-cycle
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         chk("cyc_in_ready", 32'(in_ready), 32'(m_rdy));
         chk("cyc_res_valid", 32'(res_valid), 32'(m_rv));
         chk("cyc_acc", 32'(acc), 32'(m_acc));
         chk("cyc_alu_a", 32'(alu_a), 32'(m_alu_a));
         chk("cyc_alu_b", 32'(alu_b), 32'(m_alu_b));
         if (m_rv) begin
            chk("cyc_res_data", 32'(res_data), 32'(m_data));
            chk("cyc_res_zr", 32'(res_zr), 32'(m_zr));
            chk("cyc_res_ng", 32'(res_ng), 32'(m_ng));
            chk("cyc_res_err", 32'(res_err), 32'(m_err));
         end
      end
   end

   // One request/response transaction; called at a negedge, returns at a negedge
   task automatic do_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ua, input int hold,
                        input logic [W-1:0] e_data, input logic e_zr, input logic e_ng,
                        input logic e_err);
      int k;
      int lat;
      res_ready = (hold == 0);
      k = 0;
      while (!in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_use_acc = ua;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; in_a = 16'hDEAD; in_b = 16'hBEEF; in_use_acc = 1'b0;
      lat = 1;
      while (!res_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({name, "_latency"}, 32'(lat), (op > 4'd12) ? 32'd1 : 32'd2);
      chk({name, "_data"}, 32'(res_data), 32'(e_data));
      chk({name, "_zr"}, 32'(res_zr), 32'(e_zr));
      chk({name, "_ng"}, 32'(res_ng), 32'(e_ng));
      chk({name, "_err"}, 32'(res_err), 32'(e_err));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({name, "_hold_valid"}, 32'(res_valid), 32'd1);
         chk({name, "_hold_data"}, 32'(res_data), 32'(e_data));
      end
      res_ready = 1'b1;
      @(negedge clk);
      chk({name, "_done"}, 32'(res_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_use_acc = 1'b0;
      res_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_acc", 32'(acc), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      chk("rst_res_data", 32'(res_data), 32'd0);

      // Reset while an ADD is executing
      in_valid = 1'b1; in_op = 4'd9; in_a = 16'h0001; in_b = 16'h0001;
      @(posedge clk);
      #2;
      rst = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("midrst_res_valid", 32'(res_valid), 32'd0);
      chk("midrst_acc", 32'(acc), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("midrst_no_result", 32'(res_valid), 32'd0);
      end

      do_op("add",     4'd9,  16'h0001, 16'h0001, 1'b0, 0, 16'h0002, 1'b0, 1'b0, 1'b0);
      chk("add_acc", 32'(acc), 32'h0002);
      do_op("sub_neg", 4'd10, 16'h0001, 16'h0002, 1'b0, 0, 16'hFFFF, 1'b0, 1'b1, 1'b0);
      do_op("sub_zero",4'd10, 16'h0005, 16'h0005, 1'b0, 0, 16'h0000, 1'b1, 1'b0, 1'b0);
      do_op("inca",    4'd7,  16'h7FFF, 16'h0000, 1'b0, 0, 16'h8000, 1'b0, 1'b1, 1'b0);
      do_op("chain",   4'd9,  16'h0001, 16'h0000, 1'b1, 0, 16'h8001, 1'b0, 1'b1, 1'b0);
      chk("chain_acc", 32'(acc), 32'h8001);
      do_op("or_bp",   4'd12, 16'h00F0, 16'h0F00, 1'b0, 5, 16'h0FF0, 1'b0, 1'b0, 1'b0);
      do_op("zero",    4'd0,  16'h0005, 16'h0007, 1'b0, 0, 16'h0000, 1'b1, 1'b0, 1'b0);
      do_op("one",     4'd1,  16'h1111, 16'h2222, 1'b0, 0, 16'h0001, 1'b0, 1'b0, 1'b0);
      do_op("neg1",    4'd2,  16'h0000, 16'h0000, 1'b0, 0, 16'hFFFF, 1'b0, 1'b1, 1'b0);
      do_op("passb",   4'd4,  16'h0000, 16'hBEEF, 1'b0, 0, 16'hBEEF, 1'b0, 1'b1, 1'b0);
      do_op("nota",    4'd5,  16'h00FF, 16'h0000, 1'b0, 0, 16'hFF00, 1'b0, 1'b1, 1'b0);
      do_op("nega",    4'd6,  16'h0001, 16'h0000, 1'b0, 0, 16'hFFFF, 1'b0, 1'b1, 1'b0);
      do_op("deca",    4'd8,  16'h0000, 16'h0000, 1'b0, 0, 16'hFFFF, 1'b0, 1'b1, 1'b0);
      do_op("and",     4'd11, 16'hF0F0, 16'h3C3C, 1'b0, 0, 16'h3030, 1'b0, 1'b0, 1'b0);
      do_op("passa",   4'd3,  16'h1234, 16'h5555, 1'b0, 0, 16'h1234, 1'b0, 1'b0, 1'b0);
      chk("passa_acc", 32'(acc), 32'h1234);
      do_op("ill14",   4'd14, 16'hAAAA, 16'hBBBB, 1'b1, 2, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("ill14_acc", 32'(acc), 32'h1234);
      chk("ill14_alu_a", 32'(alu_a), 32'h1234);
      chk("ill14_alu_b", 32'(alu_b), 32'h5555);
      do_op("ill15",   4'd15, 16'h0001, 16'h0001, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b1);
      do_op("acc_sub", 4'd10, 16'h2000, 16'h0000, 1'b1, 0, 16'h0DCC, 1'b0, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Opcode-driven sequencer placed directly around the combinational 16-bit ALU (inputs `a`, `b`, `zx`, `nx`, `zy`, `ny`, `f`, `no`; outputs `out`, `zr`, `ng`). It accepts a 4-bit operation and two operands over a valid/ready handshake, decodes the operation into the ALU's six control fields, and registers the operands and controls into the ALU. It then captures the result and flags, offers them downstream over a second valid/ready handshake, and keeps a 16-bit accumulator that can be selected as operand B for chained operations.

## Interface
Parameters:
- `WIDTH`, 16, datapath width; must match the ALU.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  sequencer can accept a request.
- `in_op`  in  4  operation code; see Operation.
- `in_a`  in  WIDTH  operand A.
- `in_b`  in  WIDTH  operand B.
- `in_use_acc`  in  1  when 1, operand B is the accumulator instead of `in_b`.
- `alu_a`, `alu_b`  out  WIDTH  registered operands to the ALU.
- `alu_zx`, `alu_nx`, `alu_zy`, `alu_ny`, `alu_no`  out  1 each  registered ALU control bits.
- `alu_f`  out  2  registered ALU function: 2'b00 = x&y, 2'b01 = x+y. Bit 1 is always 0.
- `alu_out`  in  WIDTH  ALU result.
- `alu_zr`, `alu_ng`  in  1 each  ALU zero and negative flags.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  downstream accepts the result.
- `res_data`  out  WIDTH  captured result.
- `res_zr`, `res_ng`  out  1 each  captured flags.
- `res_err`  out  1  the operation was illegal.
- `acc`  out  WIDTH  accumulator value.

## Operation
- Three-state FSM:
  - IDLE: `in_ready`=1.
  - EXEC: `in_ready`=0. The ALU settles on the registered inputs.
  - RESP: `res_valid`=1.
- Transitions:
  - IDLE→EXEC on `in_valid`&`in_ready` with a legal op.
  - IDLE→RESP directly for an illegal op.
  - EXEC→RESP unconditionally.
  - RESP→IDLE on `res_valid`&`res_ready`.
- Decode, written as zx nx zy ny f no:
  - 0 ZERO: 1 0 1 0 01 0
  - 1 ONE: 1 1 1 1 01 1
  - 2 NEG1: 1 1 1 0 01 0
  - 3 PASSA: 0 0 1 1 00 0
  - 4 PASSB: 1 1 0 0 00 0
  - 5 NOTA: 0 0 1 1 00 1
  - 6 NEGA: 0 0 1 1 01 1
  - 7 INCA: 0 1 1 1 01 1
  - 8 DECA: 0 0 1 1 01 0
  - 9 ADD: 0 0 0 0 01 0
  - 10 SUB (A−B): 0 1 0 0 01 1
  - 11 AND: 0 0 0 0 00 0
  - 12 OR: 0 1 0 1 00 1
- Ops 13–15 are illegal:
  - ALU input registers keep their previous values.
  - `res_err`=1, `res_data`=0, `res_zr`=0, `res_ng`=0.
  - Accumulator is unchanged.
- Operand B mux: `alu_b` ← `acc` when `in_use_acc`=1, else `in_b`. The value of `acc` is sampled on the accept edge.
- EXEC capture edge:
  - `res_data`←`alu_out`, `res_zr`←`alu_zr`, `res_ng`←`alu_ng`, `res_err`←0.
  - `acc`←`alu_out`.
- Arithmetic is modulo 2^WIDTH with no carry or overflow output. Flags come only from the ALU.
- `res_*` outputs stay stable while `res_valid`=1 and `res_ready`=0.
- `in_*` inputs are ignored outside IDLE.

## Timing
- Reset (asynchronous, any state) forces:
  - State to IDLE.
  - `in_ready`=1 as soon as `rst` deasserts.
  - `res_valid`=0, `res_data`=0, `res_zr`=0, `res_ng`=0, `res_err`=0, `acc`=0.
  - All `alu_*` outputs to 0.
- Reset during EXEC or RESP drops the in-flight operation; no result is produced.
- Legal op accepted at edge N:
  - `alu_*` outputs valid after N.
  - Result captured at edge N+1; `res_valid`=1 after N+1.
  - With `res_ready` held at 1, the result handshake completes at edge N+2 and `in_ready`=1 after N+2.
  - Peak throughput is one op per 3 cycles.
- Illegal op accepted at N: `res_valid`=1 after N, with `res_err`=1.
- `in_ready` and `res_valid` are never 1 in the same cycle, so accept and result handshakes cannot coincide.
- An op with `in_use_acc`=1 accepted right after a result handshake sees the accumulator already updated by that result.

## Test plan
- Reset: assert `rst` mid-EXEC → `res_valid`=0, `acc`=0, `in_ready`=1 after release; no result is emitted.
- ADD: A=0x0001, B=0x0001, `res_ready`=1 → `res_data`=0x0002, zr=0, ng=0, `acc`=0x0002. `res_valid` rises two edges after accept.
- SUB: A=0x0001, B=0x0002 → `res_data`=0xFFFF, ng=1, zr=0. Then A=0x0005, B=0x0005 → `res_data`=0x0000, zr=1.
- Chain: INCA with A=0x7FFF → `res_data`=0x8000, ng=1. Then ADD with A=0x0001 and `in_use_acc`=1 → `res_data`=0x8001, `acc`=0x8001.
- Backpressure: OR with A=0x00F0, B=0x0F00 and `res_ready`=0 for 5 cycles → `res_data`=0x0FF0 held stable, `in_ready`=0 throughout. Handshake completes on the first cycle with `res_ready`=1.
- Illegal op 14 with `acc`=0x1234 → `res_err`=1 one edge after accept, `res_data`=0, `acc` stays 0x1234, `alu_*` outputs unchanged.
